// File: rtl/doa_frame_sequencer_if.sv
// Control/status bundle between the DOA frame sequencer, its pipeline stages and the HPS register file.
// slave is the sequencer's view; master is the view of whatever drives the stage events and run controls.
interface doa_frame_sequencer_if #(
  parameter int CNT_W = 16
);
  logic              run;
  logic              single;
  logic              abort;
  logic              err_clr;
  logic              frame_ready;
  logic              fft_done;
  logic              detectdone;
  logic              weightdone;
  logic [9:0]        maxbin;
  logic signed [7:0] doa;

  logic              capture_en;
  logic              fft_start;
  logic              detect_start;
  logic              busy;
  logic              result_valid;
  logic signed [7:0] doa_out;
  logic [9:0]        bin_out;
  logic [CNT_W-1:0]  frame_count;
  logic              timeout_err;
  logic [2:0]        err_stage;

  modport slave (
    input  run, single, abort, err_clr,
    input  frame_ready, fft_done, detectdone, weightdone, maxbin, doa,
    output capture_en, fft_start, detect_start, busy, result_valid,
    output doa_out, bin_out, frame_count, timeout_err, err_stage
  );

  modport master (
    output run, single, abort, err_clr,
    output frame_ready, fft_done, detectdone, weightdone, maxbin, doa,
    input  capture_en, fft_start, detect_start, busy, result_valid,
    input  doa_out, bin_out, frame_count, timeout_err, err_stage
  );
endinterface

// File: rtl/doa_frame_sequencer.sv
// Frame scheduler for the DOA pipeline: capture -> FFT -> peak detect -> beam search -> publish,
// with a per-wait timeout, sticky error reporting and a wrapping frame counter.
//
// state   | meaning
// IDLE    | waiting for run (blocked while timeout_err is set)
// CAPTURE | sample buffer filling, capture_en high, waiting for frame_ready
// FFT     | waiting for fft_done
// DETECT  | waiting for detectdone level
// WEIGH   | beam search running, waiting for weightdone
// PUBLISH | one cycle with result_valid high, picks next frame or IDLE
module doa_frame_sequencer #(
  parameter int TIMEOUT_CYC = 1048576,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  doa_frame_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CAPTURE = 3'd1;
  localparam logic [2:0] FFT     = 3'd2;
  localparam logic [2:0] DETECT  = 3'd3;
  localparam logic [2:0] WEIGH   = 3'd4;
  localparam logic [2:0] PUBLISH = 3'd5;

  localparam logic [23:0] TLIM = 24'(TIMEOUT_CYC - 1);

  logic [2:0]        state;
  logic              single_lat;
  logic [23:0]       tcnt;
  logic              capture_en;
  logic              fft_start;
  logic              detect_start;
  logic              result_valid;
  logic signed [7:0] doa_out;
  logic [9:0]        bin_out;
  logic [CNT_W-1:0]  frame_count;
  logic              timeout_err;
  logic [2:0]        err_stage;

  logic              in_wait;
  logic              evt;
  logic              tc_hit;

  // Event each wait state is looking for; anything else arriving is simply not seen.
  always_comb begin
    in_wait = 1'b0;
    evt     = 1'b0;
    case (state)
      CAPTURE: begin in_wait = 1'b1; evt = bus.frame_ready; end
      FFT:     begin in_wait = 1'b1; evt = bus.fft_done;    end
      DETECT:  begin in_wait = 1'b1; evt = bus.detectdone;  end
      WEIGH:   begin in_wait = 1'b1; evt = bus.weightdone;  end
      default: begin in_wait = 1'b0; evt = 1'b0;            end
    endcase
  end

  assign tc_hit = (tcnt == TLIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      single_lat   <= 1'b0;
      tcnt         <= '0;
      capture_en   <= 1'b0;
      fft_start    <= 1'b0;
      detect_start <= 1'b0;
      result_valid <= 1'b0;
      doa_out      <= '0;
      bin_out      <= '0;
      frame_count  <= '0;
      timeout_err  <= 1'b0;
      err_stage    <= '0;
    end else begin
      fft_start    <= 1'b0;
      detect_start <= 1'b0;
      result_valid <= 1'b0;

      // A timeout later in this block overrides a coincident clear.
      if (bus.err_clr) begin
        timeout_err <= 1'b0;
        err_stage   <= '0;
      end

      if (bus.abort) begin
        state      <= IDLE;
        capture_en <= 1'b0;
        tcnt       <= '0;
      end else if (in_wait && !evt) begin
        if (tc_hit) begin
          timeout_err <= 1'b1;
          err_stage   <= state;
          state       <= IDLE;
          capture_en  <= 1'b0;
          tcnt        <= '0;
        end else begin
          tcnt <= tcnt + 24'd1;
        end
      end else begin
        case (state)
          IDLE: begin
            tcnt <= '0;
            if (bus.run && !timeout_err) begin
              single_lat <= bus.single;
              capture_en <= 1'b1;
              state      <= CAPTURE;
            end
          end
          CAPTURE: begin
            capture_en <= 1'b0;
            fft_start  <= 1'b1;
            tcnt       <= '0;
            state      <= FFT;
          end
          FFT: begin
            detect_start <= 1'b1;
            tcnt         <= '0;
            state        <= DETECT;
          end
          DETECT: begin
            tcnt  <= '0;
            state <= WEIGH;
          end
          WEIGH: begin
            // Result is taken from the weightdone cycle so it is visible while in PUBLISH.
            doa_out      <= bus.doa;
            bin_out      <= bus.maxbin;
            result_valid <= 1'b1;
            frame_count  <= frame_count + 1'b1;
            tcnt         <= '0;
            state        <= PUBLISH;
          end
          PUBLISH: begin
            tcnt <= '0;
            if (bus.run && !single_lat) begin
              capture_en <= 1'b1;
              state      <= CAPTURE;
            end else begin
              state <= IDLE;
            end
          end
          default: begin
            capture_en <= 1'b0;
            tcnt       <= '0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.capture_en   = capture_en;
  assign bus.fft_start    = fft_start;
  assign bus.detect_start = detect_start;
  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = result_valid;
  assign bus.doa_out      = doa_out;
  assign bus.bin_out      = bin_out;
  assign bus.frame_count  = frame_count;
  assign bus.timeout_err  = timeout_err;
  assign bus.err_stage    = err_stage;

endmodule

// File: tb/tb_doa_frame_sequencer.sv
// Directed bench for doa_frame_sequencer with a short timeout and a 4-bit frame counter.
module tb_doa_frame_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  doa_frame_sequencer_if #(.CNT_W(4)) bus ();

  doa_frame_sequencer #(.TIMEOUT_CYC(64), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_fr();
    bus.frame_ready = 1'b1; step(1); bus.frame_ready = 1'b0;
  endtask

  task automatic pulse_fd();
    bus.fft_done = 1'b1; step(1); bus.fft_done = 1'b0;
  endtask

  // Starts in CAPTURE, ends in the PUBLISH cycle.
  task automatic run_frame(input int d, input int b, input bit drop_run);
    if (drop_run) bus.run = 1'b0;
    step(3);
    pulse_fr();
    step(2);
    pulse_fd();
    step(2);
    bus.detectdone = 1'b1; step(1); bus.detectdone = 1'b0;
    step(2);
    bus.doa        = 8'(d);
    bus.maxbin     = 10'(b);
    bus.weightdone = 1'b1; step(1); bus.weightdone = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.run = 1'b0; bus.single = 1'b0; bus.abort = 1'b0; bus.err_clr = 1'b0;
    bus.frame_ready = 1'b0; bus.fft_done = 1'b0; bus.detectdone = 1'b0;
    bus.weightdone = 1'b0; bus.maxbin = '0; bus.doa = '0;
    step(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_capture_en", bus.capture_en, 0);
    chk("rst_frame_count", bus.frame_count, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    reset = 1'b0;

    // nominal single frame
    bus.run = 1'b1; bus.single = 1'b1;
    step(1);
    chk("nom_capture_en", bus.capture_en, 1);
    chk("nom_busy", bus.busy, 1);
    pulse_fd();
    chk("stray_fd_detect_start", bus.detect_start, 0);
    chk("stray_fd_capture_en", bus.capture_en, 1);
    step(6);
    pulse_fr();
    chk("nom_fft_start", bus.fft_start, 1);
    chk("nom_capture_off", bus.capture_en, 0);
    step(1);
    chk("nom_fft_start_1cyc", bus.fft_start, 0);
    step(7);
    pulse_fd();
    chk("nom_detect_start", bus.detect_start, 1);
    step(1);
    chk("nom_detect_start_1cyc", bus.detect_start, 0);
    bus.detectdone = 1'b1;
    step(18);
    bus.doa = -8'sd35; bus.maxbin = 10'h07A;
    bus.weightdone = 1'b1; step(1); bus.weightdone = 1'b0;
    chk("nom_result_valid", bus.result_valid, 1);
    chk("nom_doa_out", bus.doa_out, -35);
    chk("nom_bin_out", bus.bin_out, 10'h07A);
    chk("nom_frame_count", bus.frame_count, 1);
    step(1);
    chk("nom_result_valid_1cyc", bus.result_valid, 0);
    chk("nom_busy_end", bus.busy, 0);
    chk("nom_capture_end", bus.capture_en, 0);
    bus.run = 1'b0; bus.detectdone = 1'b0;
    step(2);

    // continuous mode, graceful stop in frame 3
    bus.single = 1'b0; bus.run = 1'b1;
    step(1);
    run_frame(40, 10'h100, 1'b0);
    chk("cont1_result_valid", bus.result_valid, 1);
    chk("cont1_frame_count", bus.frame_count, 2);
    chk("cont1_doa_out", bus.doa_out, 40);
    step(1);
    chk("cont1_capture_reassert", bus.capture_en, 1);
    run_frame(-90, 10'h3FF, 1'b0);
    chk("cont2_frame_count", bus.frame_count, 3);
    chk("cont2_bin_out", bus.bin_out, 10'h3FF);
    chk("cont2_doa_out", bus.doa_out, -90);
    step(1);
    chk("cont2_capture_reassert", bus.capture_en, 1);
    run_frame(90, 10'h001, 1'b1);
    chk("cont3_result_valid", bus.result_valid, 1);
    chk("cont3_frame_count", bus.frame_count, 4);
    step(1);
    chk("cont3_busy_stop", bus.busy, 0);
    chk("cont3_capture_stop", bus.capture_en, 0);
    step(2);
    chk("cont3_stays_idle", bus.busy, 0);

    // timeout in FFT and error lockout
    bus.single = 1'b1; bus.run = 1'b1;
    step(1);
    pulse_fr();
    step(63);
    chk("to_not_yet", bus.timeout_err, 0);
    chk("to_busy_before", bus.busy, 1);
    step(1);
    chk("to_timeout_err", bus.timeout_err, 1);
    chk("to_err_stage", bus.err_stage, 2);
    chk("to_busy_after", bus.busy, 0);
    step(5);
    chk("to_lockout_busy", bus.busy, 0);
    chk("to_lockout_capture", bus.capture_en, 0);
    bus.err_clr = 1'b1; step(1); bus.err_clr = 1'b0;
    chk("clr_timeout_err", bus.timeout_err, 0);
    chk("clr_err_stage", bus.err_stage, 0);
    step(1);
    chk("clr_restart_busy", bus.busy, 1);
    chk("clr_restart_capture", bus.capture_en, 1);

    // fft_done exactly on the last allowed cycle
    pulse_fr();
    step(63);
    pulse_fd();
    chk("race_detect_start", bus.detect_start, 1);
    chk("race_no_err", bus.timeout_err, 0);
    chk("race_busy", bus.busy, 1);

    // abort in WEIGH, then a stray weightdone in IDLE
    bus.detectdone = 1'b1; step(1); bus.detectdone = 1'b0;
    step(2);
    bus.run = 1'b0;
    bus.abort = 1'b1; step(1); bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_capture", bus.capture_en, 0);
    bus.doa = 8'sd15; bus.maxbin = 10'h155;
    bus.weightdone = 1'b1; step(1); bus.weightdone = 1'b0;
    chk("stray_wd_result_valid", bus.result_valid, 0);
    chk("stray_wd_frame_count", bus.frame_count, 4);
    chk("stray_wd_bin_out", bus.bin_out, 10'h001);
    chk("stray_wd_capture", bus.capture_en, 0);

    // async reset in DETECT
    bus.single = 1'b0; bus.run = 1'b1;
    step(1);
    pulse_fr();
    pulse_fd();
    chk("pre_rst_detect_start", bus.detect_start, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_detect_start", bus.detect_start, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_frame_count", bus.frame_count, 0);
    chk("arst_doa_out", bus.doa_out, 0);
    chk("arst_bin_out", bus.bin_out, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 17 frames on a 4-bit counter
    step(1);
    for (int i = 0; i < 17; i++) begin
      run_frame(5 * i - 40, i, i == 16);
      chk("wrap_frame_count", bus.frame_count, (i + 1) % 16);
      step(1);
    end
    chk("wrap_final_busy", bus.busy, 0);
    chk("wrap_final_count", bus.frame_count, 1);
    chk("wrap_final_doa", bus.doa_out, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
